rf_wb_arbiter: RTL and testbench

- Shares the register file's single write port between two writeback requesters: the normal pipeline writeback (WB) and the CSR read-result path (CSR).
- Replaces the silent drop of a simultaneous losing write with a valid/ready handshake, so the loser retries until it is granted.
- Grants by fixed priority (CSR first), with a starvation guard for WB.
- Drives a registered write port into the register file and gives decode per-address hazard flags for writes still in flight.

---
 rtl/rf_wb_arbiter_pkg.sv | 19 +
 rtl/rf_wb_hazard_cmp.sv | 39 +++
 rtl/rf_wb_arbiter.sv | 122 ++++++++++++
 tb/tb_rf_wb_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Purpose: width defaults, the x0 address constant and the priority encoding.
// No logic lives here; the arbiter top and the hazard comparator import it.
package rf_wb_arbiter_pkg;

    // Default register widths (x0..x31, 32-bit registers).
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    // Register x0 is hardwired to zero; writes to it are swallowed.
    localparam logic [ADDR_W_DEF-1:0] regAddr0 = '0;

    // Arbitration priority, derived each cycle from the starvation counter.
    typedef enum logic {
        PRIO_CSR = 1'b0,
        PRIO_WB  = 1'b1
    } prio_t;

endpackage

// File: rtl/rf_wb_hazard_cmp.sv
// Purpose: flags a decode source register that still has a write in flight.
// Latency: purely combinational, no state.
// Backpressure: none; observes the arbiter request and issue signals only.
//
// Ports:
//   chk_addr            source register being decoded
//   rf_we/rf_waddr      write currently being issued to the register file
//   csr_valid/csr_addr  CSR writeback request (accepted or still waiting)
//   wb_valid/wb_addr    pipeline writeback request (accepted or still waiting)
//   hazard              a pending write targets chk_addr (never for x0)
module rf_wb_hazard_cmp
    import rf_wb_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] chk_addr,
    input  logic              rf_we,
    input  logic [ADDR_W-1:0] rf_waddr,
    input  logic              csr_valid,
    input  logic [ADDR_W-1:0] csr_addr,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    output logic              hazard
);

    localparam logic [ADDR_W-1:0] ADDR_X0 = ADDR_W'(regAddr0);

    logic hit_issue;
    logic hit_csr;
    logic hit_wb;

    assign hit_issue = rf_we     && (rf_waddr == chk_addr);
    assign hit_csr   = csr_valid && (csr_addr == chk_addr);
    assign hit_wb    = wb_valid  && (wb_addr  == chk_addr);

    // x0 always reads as zero, so it can never be a hazard.
    assign hazard = (chk_addr != ADDR_X0) && (hit_issue || hit_csr || hit_wb);

endmodule

// File: rtl/rf_wb_arbiter.sv
// Purpose: shares the register-file write port between CSR and WB writeback.
// Latency: a request accepted in cycle N appears on rf_we/rf_waddr/rf_wdata in N+1.
// Backpressure: valid/ready per requester; the loser holds its request until granted.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   csr_valid/addr/data, csr_ready CSR read-result writeback handshake
//   wb_valid/addr/data, wb_ready   pipeline writeback handshake
//   rf_we/rf_waddr/rf_wdata        registered register-file write port
//   chk_addr1/2, hazard1/2         decode source addresses and in-flight flags
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              csr_valid,
    input  logic [ADDR_W-1:0] csr_addr,
    input  logic [DATA_W-1:0] csr_data,
    output logic              csr_ready,

    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_ready,

    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,

    input  logic [ADDR_W-1:0] chk_addr1,
    input  logic [ADDR_W-1:0] chk_addr2,
    output logic              hazard1,
    output logic              hazard2
);

    localparam logic [ADDR_W-1:0] ADDR_X0        = ADDR_W'(regAddr0);
    localparam logic [3:0]        STARVE_MAX_CNT = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;
    prio_t      prio;

    logic csr_act;   // CSR wants the port (valid, non-x0)
    logic wb_act;    // WB wants the port (valid, non-x0)
    logic conflict;  // both want the port for different registers
    logic csr_fire;
    logic wb_fire;

    assign csr_act  = csr_valid && (csr_addr != ADDR_X0);
    assign wb_act   = wb_valid  && (wb_addr  != ADDR_X0);
    assign conflict = csr_act && wb_act && (csr_addr != wb_addr);

    // WB is promoted for exactly one grant once it has waited STARVE_MAX cycles;
    // the counter clears on that grant, which drops priority back to CSR.
    assign prio = (starve_cnt == STARVE_MAX_CNT) ? PRIO_WB : PRIO_CSR;

    // Ready is a function of valids, addresses and the counter only. Without a
    // conflict both sides are ready: x0 writes are swallowed, a lone request
    // owns the port, and same-address requests merge into one write.
    assign csr_ready = !conflict || (prio == PRIO_CSR);
    assign wb_ready  = !conflict || (prio == PRIO_WB);

    assign csr_fire = csr_act && csr_ready;
    assign wb_fire  = wb_act  && wb_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            starve_cnt <= '0;
        end else begin
            rf_we <= csr_fire || wb_fire;
            // On a same-address merge both fire; CSR data takes precedence.
            if (csr_fire) begin
                rf_waddr <= csr_addr;
                rf_wdata <= csr_data;
            end else if (wb_fire) begin
                rf_waddr <= wb_addr;
                rf_wdata <= wb_data;
            end

            // An x0 WB request (valid, zero address) leaves the counter alone.
            if (!wb_valid || wb_fire) begin
                starve_cnt <= '0;
            end else if (wb_act && !wb_ready && (starve_cnt != STARVE_MAX_CNT)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

    rf_wb_hazard_cmp #(
        .ADDR_W (ADDR_W)
    ) u_hazard1 (
        .chk_addr  (chk_addr1),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .csr_valid (csr_valid),
        .csr_addr  (csr_addr),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .hazard    (hazard1)
    );

    rf_wb_hazard_cmp #(
        .ADDR_W (ADDR_W)
    ) u_hazard2 (
        .chk_addr  (chk_addr2),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .csr_valid (csr_valid),
        .csr_addr  (csr_addr),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .hazard    (hazard2)
    );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: linear stimulus, hand-computed expectations.
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        csr_valid;
    logic [4:0]  csr_addr;
    logic [31:0] csr_data;
    logic        csr_ready;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  chk_addr1;
    logic [4:0]  chk_addr2;
    logic        hazard1;
    logic        hazard2;

    int checks = 0;
    int errors = 0;

    rf_wb_arbiter #(
        .DATA_W     (32),
        .ADDR_W     (5),
        .STARVE_MAX (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .csr_valid (csr_valid),
        .csr_addr  (csr_addr),
        .csr_data  (csr_data),
        .csr_ready (csr_ready),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .wb_ready  (wb_ready),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .chk_addr1 (chk_addr1),
        .chk_addr2 (chk_addr2),
        .hazard1   (hazard1),
        .hazard2   (hazard2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_issue(input string tag, input logic [4:0] addr, input logic [31:0] data);
        check({tag, "_we"},    32'(rf_we),    32'd1);
        check({tag, "_waddr"}, 32'(rf_waddr), 32'(addr));
        check({tag, "_wdata"}, rf_wdata,      data);
    endtask

    initial begin
        rst       = 1'b1;
        csr_valid = 1'b0;
        csr_addr  = '0;
        csr_data  = '0;
        wb_valid  = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        chk_addr1 = '0;
        chk_addr2 = '0;

        // Reset state
        step();
        step();
        check("rst_we",     32'(rf_we),          32'd0);
        check("rst_waddr",  32'(rf_waddr),       32'd0);
        check("rst_wdata",  rf_wdata,            32'd0);
        check("rst_starve", 32'(dut.starve_cnt), 32'd0);
        rst = 1'b0;

        // Single WB request: accepted at once, issued next cycle
        wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
        #1;
        check("single_wb_ready", 32'(wb_ready), 32'd1);
        step();
        wb_valid = 1'b0;
        check_issue("single_wb", 5'd5, 32'hDEADBEEF);
        step();
        check("single_wb_idle", 32'(rf_we), 32'd0);

        // Conflict, CSR wins by default; WB follows one cycle later
        csr_valid = 1'b1; csr_addr = 5'd3; csr_data = 32'h11;
        wb_valid  = 1'b1; wb_addr  = 5'd4; wb_data  = 32'h22;
        #1;
        check("conf_csr_ready", 32'(csr_ready), 32'd1);
        check("conf_wb_ready0", 32'(wb_ready),  32'd0);
        step();
        csr_valid = 1'b0;
        #1;
        check_issue("conf_csr", 5'd3, 32'h11);
        check("conf_wb_ready1", 32'(wb_ready), 32'd1);
        step();
        wb_valid = 1'b0;
        check_issue("conf_wb", 5'd4, 32'h22);
        step();

        // Starvation: CSR to x1 held, WB to x7 held; WB wins on 4th cycle
        csr_valid = 1'b1; csr_addr = 5'd1; csr_data = 32'hC1;
        wb_valid  = 1'b1; wb_addr  = 5'd7; wb_data  = 32'h77;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("starve_cnt_%0d", i), 32'(dut.starve_cnt), 32'(i));
            check($sformatf("starve_wb_blk_%0d", i), 32'(wb_ready), 32'd0);
            check($sformatf("starve_csr_ok_%0d", i), 32'(csr_ready), 32'd1);
            step();
            check_issue($sformatf("starve_csr_iss_%0d", i), 5'd1, 32'hC1);
        end
        #1;
        check("starve_cnt_max",  32'(dut.starve_cnt), 32'd3);
        check("starve_wb_grant", 32'(wb_ready),  32'd1);
        check("starve_csr_blk",  32'(csr_ready), 32'd0);
        step();
        wb_valid = 1'b0;
        #1;
        check_issue("starve_wb_iss", 5'd7, 32'h77);
        check("starve_cnt_clr",   32'(dut.starve_cnt), 32'd0);
        check("starve_csr_again", 32'(csr_ready), 32'd1);
        step();
        csr_valid = 1'b0;
        check_issue("starve_csr_after", 5'd1, 32'hC1);
        step();

        // Same address merge: CSR data wins, one write only
        csr_valid = 1'b1; csr_addr = 5'd9; csr_data = 32'hAA;
        wb_valid  = 1'b1; wb_addr  = 5'd9; wb_data  = 32'h55;
        #1;
        check("merge_csr_ready", 32'(csr_ready), 32'd1);
        check("merge_wb_ready",  32'(wb_ready),  32'd1);
        step();
        csr_valid = 1'b0; wb_valid = 1'b0;
        check_issue("merge", 5'd9, 32'hAA);
        step();
        check("merge_single", 32'(rf_we), 32'd0);

        // WB to x0 alongside CSR to x2
        csr_valid = 1'b1; csr_addr = 5'd2; csr_data = 32'h2222;
        wb_valid  = 1'b1; wb_addr  = 5'd0; wb_data  = 32'h9999;
        #1;
        check("x0_csr_ready", 32'(csr_ready), 32'd1);
        check("x0_wb_ready",  32'(wb_ready),  32'd1);
        step();
        csr_valid = 1'b0; wb_valid = 1'b0;
        check_issue("x0_csr", 5'd2, 32'h2222);
        check("x0_starve", 32'(dut.starve_cnt), 32'd0);
        step();
        check("x0_idle", 32'(rf_we), 32'd0);

        // Hazard tracking and mid-operation reset
        chk_addr1 = 5'd6; chk_addr2 = 5'd0;
        csr_valid = 1'b1; csr_addr = 5'd6; csr_data = 32'h66;
        #1;
        check("haz_pending",   32'(hazard1), 32'd1);
        check("haz_x0_pend",   32'(hazard2), 32'd0);
        step();
        csr_valid = 1'b0;
        #1;
        check_issue("haz", 5'd6, 32'h66);
        check("haz_issue",     32'(hazard1), 32'd1);
        check("haz_x0_issue",  32'(hazard2), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("rst_mid_we",    32'(rf_we),   32'd0);
        check("haz_cleared",   32'(hazard1), 32'd0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
